// File: rtl/gfx_write_arbiter.sv
// Three-way round-robin write arbiter feeding the DDR2 address and write-data FIFOs.
// Each granted burst is one address command plus two 128-bit data beats.
module gfx_write_arbiter #(
    parameter int unsigned ADDR_W = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [127:0]      din0,
    input  logic [127:0]      din1,
    input  logic [127:0]      din2,
    input  logic [15:0]       mask0,
    input  logic [15:0]       mask1,
    input  logic [15:0]       mask2,
    output logic [2:0]        ack,
    output logic              last,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [2:0]        af_cmd_din,
    output logic [ADDR_W-1:0] af_addr_din,
    output logic              af_wr_en,
    output logic [127:0]      wdf_din,
    output logic [15:0]       wdf_mask_din,
    output logic              wdf_wr_en,
    output logic              busy
);

    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] g, g_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             req_g;

    // Rotating priority search: ptr+1, ptr+2, ptr+3 (mod 3).
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == IDX_W'(2)) ? '0 : IDX_W'(cand + IDX_W'(1));
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Data-path muxes steered by the registered grant.
    always_comb begin
        case (g)
            2'd1: begin
                req_g        = req[1];
                af_addr_din  = addr1;
                wdf_din      = din1;
                wdf_mask_din = mask1;
            end
            2'd2: begin
                req_g        = req[2];
                af_addr_din  = addr2;
                wdf_din      = din2;
                wdf_mask_din = mask2;
            end
            default: begin
                req_g        = req[0];
                af_addr_din  = addr0;
                wdf_din      = din0;
                wdf_mask_din = mask0;
            end
        endcase
    end

    assign af_cmd_din = 3'b000;
    assign busy       = (state != IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= IDX_W'(2);
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        af_wr_en  = 1'b0;
        wdf_wr_en = 1'b0;
        ack       = '0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    g_nxt     = pick;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (!req_g) begin
                    state_nxt = IDLE;
                end else if (!af_full && !wdf_full) begin
                    af_wr_en  = 1'b1;
                    wdf_wr_en = 1'b1;
                    ack       = 3'(3'd1 << g);
                    state_nxt = BEAT1;
                end
            end
            BEAT1: begin
                // Requester holds beat-1 data until last, so req is not consulted here.
                if (!wdf_full) begin
                    wdf_wr_en = 1'b1;
                    ack       = 3'(3'd1 << g);
                    last      = 1'b1;
                    ptr_nxt   = g;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Enables are held off while reset is asserted even if state has not yet cleared.
        if (rst) begin
            af_wr_en  = 1'b0;
            wdf_wr_en = 1'b0;
            ack       = '0;
            last      = 1'b0;
        end
    end

endmodule

// File: tb/tb_gfx_write_arbiter.sv
// Directed bench for gfx_write_arbiter: rotation, single burst data path,
// FIFO back-pressure, abort and mid-burst reset.
module tb_gfx_write_arbiter;

    localparam int unsigned ADDR_W = 31;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic [127:0]      din0, din1, din2;
    logic [15:0]       mask0, mask1, mask2;
    logic [2:0]        ack;
    logic              last;
    logic              af_full, wdf_full;
    logic [2:0]        af_cmd_din;
    logic [ADDR_W-1:0] af_addr_din;
    logic              af_wr_en;
    logic [127:0]      wdf_din;
    logic [15:0]       wdf_mask_din;
    logic              wdf_wr_en;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // {ack[2:0], last, af_wr_en, wdf_wr_en, busy}
    logic [6:0] obs;
    assign obs = {ack, last, af_wr_en, wdf_wr_en, busy};

    gfx_write_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .addr0        (addr0),
        .addr1        (addr1),
        .addr2        (addr2),
        .din0         (din0),
        .din1         (din1),
        .din2         (din2),
        .mask0        (mask0),
        .mask1        (mask1),
        .mask2        (mask2),
        .ack          (ack),
        .last         (last),
        .af_full      (af_full),
        .wdf_full     (wdf_full),
        .af_cmd_din   (af_cmd_din),
        .af_addr_din  (af_addr_din),
        .af_wr_en     (af_wr_en),
        .wdf_din      (wdf_din),
        .wdf_mask_din (wdf_mask_din),
        .wdf_wr_en    (wdf_wr_en),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        req      = 3'b000;
        af_full  = 1'b0;
        wdf_full = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        req      = 3'b111;
        af_full  = 1'b0;
        wdf_full = 1'b0;
        step();
        step();
        #1;
        total++;
        if (obs !== 7'b000_0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b", obs, 7'b000_0000);
        end
        total++;
        if (af_cmd_din !== 3'b000) begin
            bad++;
            $display("FAIL reset_cmd: got %b want 000", af_cmd_din);
        end
        rst = 1'b0;
        req = 3'b000;
        step();
    endtask

    // All three requesting: grants 0,1,2,0, each burst IDLE/CMD/BEAT1.
    task automatic test_round_robin;
        logic [6:0] exp_tab [12];
        exp_tab = '{7'b000_0000, 7'b001_0111, 7'b001_1011,
                    7'b000_0000, 7'b010_0111, 7'b010_1011,
                    7'b000_0000, 7'b100_0111, 7'b100_1011,
                    7'b000_0000, 7'b001_0111, 7'b001_1011};
        do_reset();
        req = 3'b111;
        for (int c = 0; c < 12; c++) begin
            #1;
            total++;
            if (obs !== exp_tab[c]) begin
                bad++;
                $display("FAIL round_robin cycle %0d: got %b want %b", c, obs, exp_tab[c]);
            end
            step();
        end
        req = 3'b000;
        step();
    endtask

    task automatic test_single_burst;
        do_reset();
        req   = 3'b010;
        addr1 = 31'h100;
        din1  = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
        mask1 = 16'h00F0;
        #1;
        total++;
        if (obs !== 7'b000_0000) begin
            bad++;
            $display("FAIL single_idle: got %b want %b", obs, 7'b000_0000);
        end
        step();
        #1;
        total++;
        if (obs !== 7'b010_0111 || af_addr_din !== 31'h100) begin
            bad++;
            $display("FAIL single_cmd: got %b addr %h want %b addr 100", obs, af_addr_din, 7'b010_0111);
        end
        total++;
        if (wdf_din !== 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004 || wdf_mask_din !== 16'h00F0) begin
            bad++;
            $display("FAIL single_beat0: got %h/%h want A beat", wdf_din, wdf_mask_din);
        end
        step();
        din1  = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
        mask1 = 16'h0000;
        #1;
        total++;
        if (obs !== 7'b010_1011 || wdf_din !== 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004) begin
            bad++;
            $display("FAIL single_beat1: got %b %h want %b B beat", obs, wdf_din, 7'b010_1011);
        end
        step();
        // ptr is now 1, so with all requesting requester 2 goes next.
        req = 3'b111;
        addr2 = 31'h300;
        step();
        #1;
        total++;
        if (ack !== 3'b100 || af_addr_din !== 31'h300) begin
            bad++;
            $display("FAIL single_next_grant: got ack %b addr %h want 100 addr 300", ack, af_addr_din);
        end
        req = 3'b000;
        step();
        step();
    endtask

    task automatic test_af_full;
        do_reset();
        req     = 3'b001;
        af_full = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (obs !== 7'b000_0001) begin
                bad++;
                $display("FAIL af_full_hold cycle %0d: got %b want %b", c, obs, 7'b000_0001);
            end
            step();
        end
        af_full = 1'b0;
        #1;
        total++;
        if (obs !== 7'b001_0111) begin
            bad++;
            $display("FAIL af_full_release: got %b want %b", obs, 7'b001_0111);
        end
        step();
        #1;
        total++;
        if (obs !== 7'b001_1011) begin
            bad++;
            $display("FAIL af_full_beat1: got %b want %b", obs, 7'b001_1011);
        end
        req = 3'b000;
        step();
    endtask

    task automatic test_wdf_full;
        do_reset();
        req = 3'b001;
        step();
        #1;
        total++;
        if (obs !== 7'b001_0111) begin
            bad++;
            $display("FAIL wdf_full_cmd: got %b want %b", obs, 7'b001_0111);
        end
        step();
        wdf_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (obs !== 7'b000_0001) begin
                bad++;
                $display("FAIL wdf_full_hold cycle %0d: got %b want %b", c, obs, 7'b000_0001);
            end
            step();
        end
        wdf_full = 1'b0;
        #1;
        total++;
        if (obs !== 7'b001_1011) begin
            bad++;
            $display("FAIL wdf_full_release: got %b want %b", obs, 7'b001_1011);
        end
        req = 3'b000;
        step();
        #1;
        total++;
        if (obs !== 7'b000_0000) begin
            bad++;
            $display("FAIL wdf_full_done: got %b want %b", obs, 7'b000_0000);
        end
    endtask

    task automatic test_abort;
        do_reset();
        req = 3'b101;
        step();
        req = 3'b100;
        #1;
        total++;
        if (obs !== 7'b000_0001) begin
            bad++;
            $display("FAIL abort_cmd: got %b want %b", obs, 7'b000_0001);
        end
        step();
        #1;
        total++;
        if (obs !== 7'b000_0000) begin
            bad++;
            $display("FAIL abort_idle: got %b want %b", obs, 7'b000_0000);
        end
        step();
        #1;
        total++;
        if (obs !== 7'b100_0111) begin
            bad++;
            $display("FAIL abort_next_grant: got %b want %b", obs, 7'b100_0111);
        end
        step();
        // BEAT1 completes even with req dropped.
        req = 3'b000;
        #1;
        total++;
        if (obs !== 7'b100_1011) begin
            bad++;
            $display("FAIL abort_beat1_ignores_req: got %b want %b", obs, 7'b100_1011);
        end
        step();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        req = 3'b010;
        step();
        step();
        #1;
        total++;
        if (obs !== 7'b010_1011) begin
            bad++;
            $display("FAIL midrst_beat1: got %b want %b", obs, 7'b010_1011);
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 7'b000_0000) begin
            bad++;
            $display("FAIL midrst_during: got %b want %b", obs, 7'b000_0000);
        end
        step();
        #1;
        total++;
        if (obs !== 7'b000_0000) begin
            bad++;
            $display("FAIL midrst_after: got %b want %b", obs, 7'b000_0000);
        end
        rst = 1'b0;
        req = 3'b101;
        step();
        #1;
        total++;
        if (obs !== 7'b001_0111) begin
            bad++;
            $display("FAIL midrst_first_grant: got %b want %b", obs, 7'b001_0111);
        end
        req = 3'b000;
        step();
        step();
    endtask

    initial begin
        rst      = 1'b1;
        req      = 3'b000;
        af_full  = 1'b0;
        wdf_full = 1'b0;
        addr0    = 31'h10;
        addr1    = 31'h20;
        addr2    = 31'h30;
        din0     = 128'h0;
        din1     = 128'h1;
        din2     = 128'h2;
        mask0    = 16'h0;
        mask1    = 16'h0;
        mask2    = 16'h0;
        test_reset();
        test_round_robin();
        test_single_burst();
        test_af_full();
        test_wdf_full();
        test_abort();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
